// File: rtl/compute_sched.sv
// compute_sched: two-requester round-robin scheduler in front of the
// shared compute unit; one request in flight, bounded wait on the result.
//
// Ports:
//   clk_i, rstn_i          clock, async active-low reset
//   req0_i/data0_i         requester 0 request level and operand
//   req1_i/data1_i         requester 1 request level and operand
//   gnt_o                  one-hot grant of the requester being served
//   done_o                 one-cycle completion pulse per requester
//   result_o, err_o        result / timeout flag, valid while done_o != 0
//   compute_req_o          single-cycle request pulse to the compute unit
//   cdata_o                operand held towards the compute unit
//   cvalid_i, cdata_i      compute unit result handshake
//   busy_o                 high whenever the scheduler is not idle
//   ok_cnt_o, to_cnt_o     saturating success / timeout counters
//
// Build option: define SCHED_STATS_EN to enable the counters; otherwise
// ok_cnt_o and to_cnt_o are tied to zero.

module compute_sched #(
  parameter int unsigned TIMEOUT = 50,
  parameter int unsigned DW      = 32
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  input  logic          req0_i,
  input  logic [DW-1:0] data0_i,
  input  logic          req1_i,
  input  logic [DW-1:0] data1_i,
  output logic [1:0]    gnt_o,
  output logic [1:0]    done_o,
  output logic [DW-1:0] result_o,
  output logic          err_o,
  output logic          compute_req_o,
  output logic [DW-1:0] cdata_o,
  input  logic          cvalid_i,
  input  logic [DW-1:0] cdata_i,
  output logic          busy_o,
  output logic [15:0]   ok_cnt_o,
  output logic [15:0]   to_cnt_o
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  logic [1:0]    state_q, state_d;
  logic          last_q, last_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [1:0]    gnt_q, gnt_d;
  logic [1:0]    done_q, done_d;
  logic [DW-1:0] cdata_q, cdata_d;
  logic [DW-1:0] res_q, res_d;
  logic          err_q, err_d;
  logic          creq_q, creq_d;
  logic          busy_q, busy_d;
  logic          pick0;
  logic          finish;

  // Requester 0 wins when alone, or on a tie when 1 was served last.
  assign pick0 = req0_i & (~req1_i | last_q);

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    done_d  = 2'b00;
    cdata_d = cdata_q;
    res_d   = res_q;
    err_d   = err_q;
    creq_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (req0_i | req1_i) begin
          gnt_d   = pick0 ? 2'b01 : 2'b10;
          cdata_d = pick0 ? data0_i : data1_i;
          creq_d  = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q + 16'd1;
        // A result on the last allowed cycle still counts as success.
        if (cvalid_i) begin
          res_d   = cdata_i;
          err_d   = 1'b0;
          done_d  = gnt_q;
          state_d = S_RESP;
        end else if (cnt_q == TO_LAST) begin
          res_d   = '0;
          err_d   = 1'b1;
          done_d  = gnt_q;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        last_d  = gnt_q[1];
        gnt_d   = 2'b00;
        res_d   = '0;
        err_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  assign finish = (state_q == S_WAIT) && (state_d == S_RESP);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= S_IDLE;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      gnt_q   <= 2'b00;
      done_q  <= 2'b00;
      cdata_q <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
      creq_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      cdata_q <= cdata_d;
      res_q   <= res_d;
      err_q   <= err_d;
      creq_q  <= creq_d;
      busy_q  <= busy_d;
    end
  end

  assign gnt_o         = gnt_q;
  assign done_o        = done_q;
  assign result_o      = res_q;
  assign err_o         = err_q;
  assign compute_req_o = creq_q;
  assign cdata_o       = cdata_q;
  assign busy_o        = busy_q;

`ifdef SCHED_STATS_EN
  logic [15:0] ok_q, ok_d;
  logic [15:0] to_q, to_d;

  always_comb begin
    ok_d = ok_q;
    to_d = to_q;
    if (finish) begin
      if (err_d) begin
        if (to_q != 16'hFFFF) to_d = to_q + 16'd1;
      end else begin
        if (ok_q != 16'hFFFF) ok_d = ok_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      ok_q <= '0;
      to_q <= '0;
    end else begin
      ok_q <= ok_d;
      to_q <= to_d;
    end
  end

  assign ok_cnt_o = ok_q;
  assign to_cnt_o = to_q;
`else
  logic unused_finish;
  assign unused_finish = finish;
  assign ok_cnt_o      = 16'h0000;
  assign to_cnt_o      = 16'h0000;
`endif

endmodule

// File: tb/tb_compute_sched.sv
// tb_compute_sched: vector table, random transactions against a
// transaction-level round-robin model, and reset corner sequences.

module tb_compute_sched;

  localparam int TO = 50;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req0, req1;
  logic [31:0] data0, data1;
  logic [1:0]  gnt, done;
  logic [31:0] result, cdata_out, cdata_in;
  logic        err, creq, cvalid, busy;
  logic [15:0] ok_cnt, to_cnt;

  int checks = 0;
  int errors = 0;
  int m_last;
  int ok_n, to_n;

  always #5 clk = ~clk;

  compute_sched #(.TIMEOUT(TO), .DW(32)) dut (
    .clk_i(clk), .rstn_i(rstn),
    .req0_i(req0), .data0_i(data0),
    .req1_i(req1), .data1_i(data1),
    .gnt_o(gnt), .done_o(done),
    .result_o(result), .err_o(err),
    .compute_req_o(creq), .cdata_o(cdata_out),
    .cvalid_i(cvalid), .cdata_i(cdata_in),
    .busy_o(busy),
    .ok_cnt_o(ok_cnt), .to_cnt_o(to_cnt)
  );

  typedef struct {
    bit          r0, r1;
    logic [31:0] op0, op1;
    int          dly;
    logic [31:0] rdata;
    logic [1:0]  gnt;
    logic [31:0] cd;
    logic        err;
    logic [31:0] res;
    int          lat;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int rr_pick(bit r0, bit r1, int last);
    if (r0 && r1) return (last == 1) ? 0 : 1;
    return r0 ? 0 : 1;
  endfunction

  // One transaction from the idle cycle through the idle cycle after done.
  // dly: cycles after the request pulse at which the unit answers (0=never).
  task automatic txn(input bit r0, input bit r1,
                     input logic [31:0] op0, input logic [31:0] op1,
                     input int dly, input logic [31:0] rdata,
                     input bit stale, input bit chaos,
                     input logic [1:0] e_gnt, input logic [31:0] e_cd,
                     input logic e_err, input logic [31:0] e_res,
                     input int e_lat);
    bit seen;
    int pulses;
    int lat;
    req0 = r0; req1 = r1; data0 = op0; data1 = op1;
    seen = 0;
    for (int i = 0; i < 3 && !seen; i++) begin
      @(negedge clk);
      chk("no_spurious_done", 64'(done), 64'd0);
      if (creq) seen = 1;
    end
    chk("pulse_seen", 64'(seen), 64'd1);
    if (!seen) return;
    chk("gnt_at_issue", 64'(gnt), 64'(e_gnt));
    chk("cdata_at_issue", 64'(cdata_out), 64'(e_cd));
    chk("busy_at_issue", 64'(busy), 64'd1);
    if (stale) begin
      cvalid = 1'b1;
      cdata_in = ~rdata;
    end
    if (chaos) begin
      req0 = 1'b0; req1 = 1'b0;
      data0 = $urandom; data1 = $urandom;
    end
    pulses = 0;
    lat = -1;
    for (int k = 1; k <= TO + 5; k++) begin
      @(negedge clk);
      if (done != 2'b00) begin
        lat = k;
        break;
      end
      if (creq) pulses++;
      cvalid = (k == dly);
      cdata_in = (k == dly) ? rdata : $urandom;
    end
    cvalid = 1'b0;
    chk("single_pulse", 64'(pulses), 64'd0);
    chk("done_latency", 64'(lat), 64'(e_lat));
    if (lat < 0) return;
    chk("done_bits", 64'(done), 64'(e_gnt));
    chk("result", 64'(result), 64'(e_res));
    chk("err", 64'(err), 64'(e_err));
    chk("gnt_at_done", 64'(gnt), 64'(e_gnt));
    chk("cdata_at_done", 64'(cdata_out), 64'(e_cd));
    @(negedge clk);
    chk("done_cleared", 64'(done), 64'd0);
    chk("busy_cleared", 64'(busy), 64'd0);
    chk("gnt_cleared", 64'(gnt), 64'd0);
  endtask

  task automatic model_txn(input bit r0, input bit r1,
                           input logic [31:0] op0, input logic [31:0] op1,
                           input int dly, input bit stale, input bit chaos);
    int w;
    logic [31:0] op, rd;
    bit to;
    w = rr_pick(r0, r1, m_last);
    op = (w == 0) ? op0 : op1;
    rd = op ^ 32'hDEAD_BEEF;
    to = !(dly >= 1 && dly <= TO);
    txn(r0, r1, op0, op1, dly, rd, stale, chaos,
        (w == 0) ? 2'b01 : 2'b10, op, to, to ? 32'h0 : rd,
        1 + (to ? TO : dly));
    m_last = w;
    if (to) to_n++;
    else ok_n++;
  endtask

  task automatic chk_stats(input string nm);
`ifdef SCHED_STATS_EN
    chk({nm, "_ok"}, 64'(ok_cnt), 64'(ok_n));
    chk({nm, "_to"}, 64'(to_cnt), 64'(to_n));
`else
    chk({nm, "_ok"}, 64'(ok_cnt), 64'd0);
    chk({nm, "_to"}, 64'(to_cnt), 64'd0);
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit r0, r1, st, ch;
    int sel, dly;
    logic [31:0] o0, o1;

    tbl[0] = '{1, 0, 32'h5,  32'h0,  3,  32'hA,     2'b01, 32'h5,  0, 32'hA,     4};
    tbl[1] = '{0, 1, 32'h0,  32'h33, 0,  32'h0,     2'b10, 32'h33, 1, 32'h0,    51};
    tbl[2] = '{1, 0, 32'h44, 32'h0,  50, 32'h77,    2'b01, 32'h44, 0, 32'h77,   51};
    tbl[3] = '{0, 1, 32'h0,  32'h9,  51, 32'h99,    2'b10, 32'h9,  1, 32'h0,    51};
    tbl[4] = '{1, 1, 32'h1,  32'h2,  1,  32'h101,   2'b01, 32'h1,  0, 32'h101,   2};
    tbl[5] = '{1, 1, 32'h1,  32'h2,  2,  32'h102,   2'b10, 32'h2,  0, 32'h102,   3};
    tbl[6] = '{1, 1, 32'h1,  32'h2,  1,  32'h201,   2'b01, 32'h1,  0, 32'h201,   2};
    tbl[7] = '{1, 1, 32'h1,  32'h2,  4,  32'h202,   2'b10, 32'h2,  0, 32'h202,   5};

    rstn = 1'b0;
    req0 = 1'b0; req1 = 1'b0;
    data0 = '0; data1 = '0;
    cvalid = 1'b0; cdata_in = '0;
    m_last = 1; ok_n = 0; to_n = 0;
    repeat (3) @(negedge clk);
    chk("rst_ctrl", 64'({gnt, done, busy, creq, err}), 64'd0);
    chk("rst_cdata", 64'(cdata_out), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    chk_stats("rst_stats");
    rstn = 1'b1;

    foreach (tbl[i]) begin
      txn(tbl[i].r0, tbl[i].r1, tbl[i].op0, tbl[i].op1, tbl[i].dly,
          tbl[i].rdata, 1'b0, 1'b0, tbl[i].gnt, tbl[i].cd, tbl[i].err,
          tbl[i].res, tbl[i].lat);
      m_last = (tbl[i].gnt == 2'b10) ? 1 : 0;
      if (tbl[i].err) to_n++;
      else ok_n++;
    end
    chk_stats("tbl_stats");

    for (int i = 0; i < 30; i++) begin
      r0 = 1'($urandom_range(0, 1));
      r1 = 1'($urandom_range(0, 1));
      if (!r0 && !r1) r0 = 1'b1;
      o0 = $urandom; o1 = $urandom;
      sel = int'($urandom_range(0, 9));
      if (sel < 7) dly = int'($urandom_range(1, 6));
      else if (sel == 7) dly = 0;
      else dly = int'($urandom_range(TO - 1, TO + 1));
      st = ($urandom_range(0, 3) == 0);
      ch = ($urandom_range(0, 3) == 0);
      model_txn(r0, r1, o0, o1, dly, st, ch);
    end
    chk_stats("rand_stats");

    // Reset while waiting on the unit.
    req0 = 1'b1; req1 = 1'b0; data0 = 32'h55;
    repeat (3) @(negedge clk);
    chk("pre_rst_busy", 64'(busy), 64'd1);
    rstn = 1'b0;
    #1;
    chk("async_rst_ctrl", 64'({gnt, done, busy, creq, err}), 64'd0);
    chk("async_rst_cdata", 64'(cdata_out), 64'd0);
    chk("async_rst_result", 64'(result), 64'd0);
    m_last = 1; ok_n = 0; to_n = 0;
    chk_stats("async_rst_stats");
    @(negedge clk);
    rstn = 1'b1;
    model_txn(1, 0, 32'h66, 32'h0, 2, 0, 0);
    model_txn(1, 1, 32'h11, 32'h22, 0, 0, 0);
    model_txn(1, 1, 32'h11, 32'h22, 3, 0, 0);
    model_txn(1, 1, 32'h11, 32'h22, 0, 0, 0);
    model_txn(0, 1, 32'h0, 32'h23, 1, 0, 0);
    chk_stats("final_stats");

    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
